// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
// Imported by the top level and by the testbench.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_MACK,
        IGNORE
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a FILT_LEN-sample glitch filter for one I2C line.
// Provides the filtered level plus single-cycle rise/fall pulses; everything resets to idle-high.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_riscv,
    input  logic rst_in,
    input  logic line_raw,
    output logic line,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync;
    logic          line_d;
    logic [CW-1:0] cnt;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_riscv or negedge rst_in) begin
        if (!rst_in) begin
            sync   <= 2'b11;
            line   <= 1'b1;
            line_d <= 1'b1;
            cnt    <= '0;
        end else begin
            sync   <= {sync[0], line_raw};
            line_d <= line;
            if (sync[1] == line) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                line <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = line & ~line_d;
    assign fall = ~line & line_d;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an NREGS x 8 register file with pointer-then-data framing,
// plus a host-side port onto the same registers. Never stretches SCL.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NREGS    = 16,
    parameter int         FILT_LEN = 3,
    localparam int        AW       = $clog2(NREGS)
) (
    input  logic          clk_riscv,
    input  logic          rst_in,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic          busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_riscv (clk_riscv),
        .rst_in    (rst_in),
        .line_raw  (scl_in),
        .line      (scl_f),
        .rise      (scl_rise),
        .fall      (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_riscv (clk_riscv),
        .rst_in    (rst_in),
        .line_raw  (sda_in),
        .line      (sda_f),
        .rise      (sda_rise),
        .fall      (sda_fall)
    );

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    logic [7:0]    regs [NREGS];
    logic [7:0]    tx_byte;

    state_t        state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          rw, rw_n;
    logic          first_byte, first_n;
    logic          mack, mack_n;
    logic          sda_oe_n, busy_n;
    logic          rx_we;

    assign tx_byte = regs[ptr];

    always_ff @(posedge clk_riscv or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            mack       <= I2C_NACK;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            first_byte <= first_n;
            mack       <= mack_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
        end
    end

    // NOTE: every combinational output takes a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        rw_n      = rw;
        first_n   = first_byte;
        mack_n    = mack;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        rx_we     = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR, RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                state_n  = ADDR_ACK;
                                sda_oe_n = 1'b1;
                                busy_n   = 1'b1;
                                rw_n     = shift[0];
                            end else begin
                                state_n = IGNORE;
                                busy_n  = 1'b0;
                            end
                        end else begin
                            state_n  = RX_ACK;
                            sda_oe_n = 1'b1;
                            if (first_byte) begin
                                ptr_n   = shift[AW-1:0];
                                first_n = 1'b0;
                            end else begin
                                rx_we = 1'b1;
                                ptr_n = ptr + AW'(1);
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (!rw) begin
                            state_n  = RX_BYTE;
                            sda_oe_n = 1'b0;
                            first_n  = 1'b1;
                        end else begin
                            state_n  = TX_BYTE;
                            shift_n  = tx_byte;
                            sda_oe_n = ~tx_byte[7];
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_n  = RX_BYTE;
                        sda_oe_n = 1'b0;
                    end
                end
                TX_BYTE: begin
                    // The shift register is a snapshot; host writes cannot alter bits in flight.
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_n   = TX_MACK;
                            sda_oe_n  = 1'b0;
                            ptr_n     = ptr + AW'(1);
                            bit_cnt_n = '0;
                        end else begin
                            shift_n   = {shift[6:0], 1'b0};
                            sda_oe_n  = ~shift[6];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                TX_MACK: begin
                    if (scl_rise) begin
                        mack_n = sda_f;
                    end else if (scl_fall) begin
                        if (mack == I2C_ACK) begin
                            state_n   = TX_BYTE;
                            shift_n   = tx_byte;
                            sda_oe_n  = ~tx_byte[7];
                            bit_cnt_n = '0;
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the register file is a small flop array with a defined reset value, not a RAM.
    always_ff @(posedge clk_riscv or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (rx_we) begin
                regs[ptr] <= shift;
            end
            // Host write comes last so it wins a same-cycle, same-register collision.
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
        end
    end

    always_ff @(posedge clk_riscv or negedge rst_in) begin
        if (!rst_in) begin
            host_rdata <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
        end else begin
            host_rdata <= regs[host_addr];
            wr_strobe  <= rx_we;
            if (rx_we) begin
                wr_addr <= ptr;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: table-driven host port vectors plus
// bit-banged I2C master sequences for write, read, mismatch, glitch, collision and reset.
module tb_i2c_target_regs;
    import i2c_target_pkg::*;

    localparam int Q = 10;

    logic       clk_riscv = 1'b0;
    logic       rst_in;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [3:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_target_regs dut (
        .clk_riscv  (clk_riscv),
        .rst_in     (rst_in),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .busy       (busy)
    );

    always #5 clk_riscv = ~clk_riscv;

    logic [3:0] strobe_q[$];
    int         oe_cnt    = 0;
    int         start_cnt = 0;

    always @(negedge clk_riscv) begin
        if (wr_strobe) strobe_q.push_back(wr_addr);
        if (sda_oe) oe_cnt++;
        if (dut.start_det) start_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk_riscv);
    endtask

    task automatic clock_bit(input logic v, output logic s);
        sda_m = v;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        s = sda_in;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(master_ack, s);
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk_riscv);
        host_addr = a;
        @(negedge clk_riscv);
        d = host_rdata;
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } hvec_t;

    hvec_t vecs[9];

    initial begin
        logic       ack, a1, a2, a3, a4, hit;
        logic [7:0] d;
        int         base_s, base_oe, base_st;

        vecs[0] = '{1'b1, 4'd2,  8'h3C, 8'h00};
        vecs[1] = '{1'b0, 4'd2,  8'h00, 8'h3C};
        vecs[2] = '{1'b1, 4'd15, 8'hC3, 8'h00};
        vecs[3] = '{1'b1, 4'd0,  8'h11, 8'h00};
        vecs[4] = '{1'b0, 4'd15, 8'h00, 8'hC3};
        vecs[5] = '{1'b0, 4'd0,  8'h00, 8'h11};
        vecs[6] = '{1'b0, 4'd7,  8'h00, 8'h00};
        vecs[7] = '{1'b1, 4'd2,  8'h00, 8'h3C};
        vecs[8] = '{1'b0, 4'd2,  8'h00, 8'h00};

        rst_in     = 1'b0;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        host_addr  = '0;
        host_we    = 1'b0;
        host_wdata = '0;
        repeat (5) @(negedge clk_riscv);
        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy, 0);
        check("reset wr_strobe", wr_strobe, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset host_rdata", host_rdata, 0);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_riscv);
        check("post-reset state", dut.state, IDLE);

        // Host port vectors: read returns the pre-write value with one cycle of latency.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_riscv);
            host_we    = vecs[i].we;
            host_addr  = vecs[i].addr;
            host_wdata = vecs[i].wdata;
            @(negedge clk_riscv);
            check($sformatf("host vec %0d rdata", i), host_rdata, vecs[i].exp_rdata);
            host_we = 1'b0;
        end

        // Write burst.
        base_s = strobe_q.size();
        i2c_start();
        write_byte(8'h84, ack);
        check("t1 addr ack", ack, I2C_ACK);
        check("t1 busy during", busy, 1);
        write_byte(8'h03, ack);
        check("t1 ptr ack", ack, I2C_ACK);
        write_byte(8'hA5, ack);
        check("t1 data0 ack", ack, I2C_ACK);
        write_byte(8'h5A, ack);
        check("t1 data1 ack", ack, I2C_ACK);
        i2c_stop();
        check("t1 strobe count", strobe_q.size() - base_s, 2);
        check("t1 wr_addr 0", (strobe_q.size() > base_s) ? strobe_q[base_s] : 4'hF, 3);
        check("t1 wr_addr 1", (strobe_q.size() > base_s + 1) ? strobe_q[base_s + 1] : 4'hF, 4);
        host_read(4'd4, d);
        check("t1 reg4", d, 8'h5A);
        host_read(4'd3, d);
        check("t1 reg3", d, 8'hA5);
        check("t1 busy after stop", busy, 0);

        // Read with pointer wrap.
        i2c_start();
        write_byte(8'h84, ack);
        check("t2 addr ack", ack, I2C_ACK);
        write_byte(8'h0F, ack);
        check("t2 ptr ack", ack, I2C_ACK);
        i2c_start();
        write_byte(8'h85, ack);
        check("t2 read addr ack", ack, I2C_ACK);
        read_byte(I2C_ACK, d);
        check("t2 byte0", d, 8'hC3);
        read_byte(I2C_NACK, d);
        check("t2 byte1", d, 8'h11);
        i2c_stop();
        check("t2 ptr after", dut.ptr, 1);
        check("t2 busy after", busy, 0);

        // Address mismatch.
        base_s  = strobe_q.size();
        base_oe = oe_cnt;
        i2c_start();
        write_byte(8'h90, ack);
        check("t3 addr nack", ack, I2C_NACK);
        check("t3 busy", busy, 0);
        write_byte(8'h01, ack);
        check("t3 data nack", ack, I2C_NACK);
        i2c_stop();
        check("t3 sda_oe cycles", oe_cnt - base_oe, 0);
        check("t3 strobes", strobe_q.size() - base_s, 0);

        // Glitch filter with SCL held high.
        base_st = start_cnt;
        @(negedge clk_riscv);
        sda_m = 1'b0;
        repeat (2) @(negedge clk_riscv);
        sda_m = 1'b1;
        repeat (12) @(negedge clk_riscv);
        check("t4 2-cycle glitch starts", start_cnt - base_st, 0);
        check("t4 state after glitch", dut.state, IDLE);
        sda_m = 1'b0;
        repeat (4) @(negedge clk_riscv);
        sda_m = 1'b1;
        repeat (12) @(negedge clk_riscv);
        check("t4 4-cycle pulse starts", start_cnt - base_st, 1);
        i2c_start();
        write_byte(8'h84, ack);
        check("t4 ack after start", ack, I2C_ACK);
        i2c_stop();

        // Host and I2C write the same register in the same cycle.
        base_s = strobe_q.size();
        hit    = 1'b0;
        fork
            begin
                i2c_start();
                write_byte(8'h84, a1);
                write_byte(8'h04, a2);
                write_byte(8'h5A, a3);
                i2c_stop();
            end
            begin
                for (int i = 0; i < 4000 && !hit; i++) begin
                    @(negedge clk_riscv);
                    if (dut.rx_we) begin
                        host_addr  = 4'd4;
                        host_wdata = 8'h77;
                        host_we    = 1'b1;
                        @(negedge clk_riscv);
                        host_we = 1'b0;
                        hit     = 1'b1;
                    end
                end
            end
        join
        check("t6 collision window found", hit, 1);
        check("t6 acks", {a1, a2, a3}, 3'b000);
        check("t6 strobe count", strobe_q.size() - base_s, 1);
        check("t6 wr_addr", (strobe_q.size() > base_s) ? strobe_q[base_s] : 4'hF, 4);
        host_read(4'd4, d);
        check("t6 reg4 host wins", d, 8'h77);

        // Reset while driving a zero bit in TX_BYTE (ptr=5, reg5=0).
        i2c_start();
        write_byte(8'h85, a4);
        check("t5 addr ack", a4, I2C_ACK);
        check("t5 state tx", dut.state, TX_BYTE);
        check("t5 sda_oe driving", sda_oe, 1);
        @(posedge clk_riscv);
        #2;
        rst_in = 1'b0;
        #1;
        check("t5 sda_oe async release", sda_oe, 0);
        check("t5 state idle", dut.state, IDLE);
        check("t5 busy cleared", busy, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk_riscv);
        rst_in = 1'b1;
        host_read(4'd4, d);
        check("t5 reg4 cleared", d, 8'h00);
        host_read(4'd3, d);
        check("t5 reg3 cleared", d, 8'h00);
        host_read(4'd15, d);
        check("t5 reg15 cleared", d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
